// File: rtl/dig_out_capture_if.sv
// Capture-side bus: the result stream and its strobe, the arm/trigger controls,
// the readout handshake and status.
interface dig_out_capture_if #(
  parameter int BW = 6,
  parameter int AW = 6
);
  localparam int DW = BW + 15;

  logic                 OUT_CLK;
  logic signed [DW-1:0] OUT;
  logic                 ARM;
  logic                 TRIG_MODE;
  logic signed [DW-1:0] THRESH;
  logic                 RD_REQ;
  logic signed [DW-1:0] RD_DATA;
  logic                 RD_VALID;
  logic                 BUSY;
  logic                 DONE;
  logic                 OVERRUN;
  logic [AW:0]          SAMPLE_CNT;

  // Test equipment side: drives the stream and the controls.
  modport master (
    output OUT_CLK, OUT, ARM, TRIG_MODE, THRESH, RD_REQ,
    input  RD_DATA, RD_VALID, BUSY, DONE, OVERRUN, SAMPLE_CNT
  );

  // Capture block side.
  modport slave (
    input  OUT_CLK, OUT, ARM, TRIG_MODE, THRESH, RD_REQ,
    output RD_DATA, RD_VALID, BUSY, DONE, OVERRUN, SAMPLE_CNT
  );
endinterface

// File: rtl/dig_out_capture.sv
// Oversampled capture of the signed result stream into a 2^AW buffer with
// arm/trigger control and a request/valid readout port.
module dig_out_capture #(
  parameter int BW          = 6,
  parameter int AW          = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RES,
  dig_out_capture_if.slave   bus
);
  localparam int DW    = BW + 15;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FULL    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;
  logic                   stb;
  logic signed [DW-1:0]   smp_p2;
  logic                   vld_p2;
  logic                   trig_hit;

  logic                   clr;
  logic                   wr_en;
  logic                   rd_en;
  logic                   set_ovr;
  logic                   busy;
  logic                   done;

  logic [AW:0]            cnt_q;
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic                   ovr_q;
  logic signed [DW-1:0]   rd_data_q;
  logic                   rd_vld_q;

  logic signed [DW-1:0]   mem [DEPTH];

  // ---- stage p0/p1: OUT_CLK synchronizer and edge history
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.OUT_CLK};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // Falling edge: OUT was launched on the rise and is settled by now.
  assign stb = hist_p1 & ~sync_p0[SYNC_STAGES-1];

  // ---- stage p2: sampled word and its valid
  always_ff @(posedge CLK) begin
    if (stb) smp_p2 <= bus.OUT;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) vld_p2 <= 1'b0;
    else     vld_p2 <= stb;
  end

  assign trig_hit = !bus.TRIG_MODE || (smp_p2 >= bus.THRESH);

  // ---- control FSM
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.ARM) state_d = S_ARMED;
      S_ARMED: begin
        if (!bus.ARM)                state_d = S_IDLE;
        else if (vld_p2 && trig_hit) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!bus.ARM)                          state_d = S_IDLE;
        else if (vld_p2 && cnt_q == CNT_LAST) state_d = S_FULL;
      end
      S_FULL:    if (bus.RD_REQ && rd_ptr_q == PTR_LAST) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // An abort (ARM low) always beats a concurrent sample.
  always_comb begin
    clr     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    set_ovr = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:    clr = bus.ARM;
      S_ARMED: begin
        busy  = 1'b1;
        wr_en = bus.ARM && vld_p2 && trig_hit;
      end
      S_CAPTURE: begin
        busy  = 1'b1;
        wr_en = bus.ARM && vld_p2;
      end
      S_FULL: begin
        done    = 1'b1;
        rd_en   = bus.RD_REQ;
        set_ovr = vld_p2;
      end
      default: ;
    endcase
  end

  // ---- write side: pointer, count, overrun
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      ovr_q    <= 1'b0;
    end else if (clr) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (set_ovr) ovr_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_q] <= smp_p2;
  end

  // ---- read side: one registered word per request, pointer wraps after the last
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign bus.RD_DATA    = rd_data_q;
  assign bus.RD_VALID   = rd_vld_q;
  assign bus.BUSY       = busy;
  assign bus.DONE       = done;
  assign bus.OVERRUN    = ovr_q;
  assign bus.SAMPLE_CNT = cnt_q;

endmodule

// File: tb/tb_dig_out_capture.sv
// Scoreboard bench for dig_out_capture: a trigger model queues the words that
// should land in the buffer, and every readout word is popped and compared.
module tb_dig_out_capture;
  localparam int BW    = 6;
  localparam int AW    = 6;
  localparam int DW    = BW + 15;
  localparam int DEPTH = 1 << AW;

  logic CLK = 1'b0;
  logic RES;

  dig_out_capture_if #(.BW(BW), .AW(AW)) bus ();

  dig_out_capture #(.BW(BW), .AW(AW), .SYNC_STAGES(2)) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  longint sbq[$];
  bit     m_armed;
  bit     m_trig;
  bit     m_mode;
  longint m_th;
  int     m_cnt;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic arm_model(input bit mode, input longint th);
    sbq.delete();
    m_cnt   = 0;
    m_trig  = 1'b0;
    m_mode  = mode;
    m_th    = th;
    m_armed = 1'b1;
  endtask

  // One OUT_CLK period; the word is held through the low phase.
  task automatic send(input longint v, input int ph);
    bus.OUT     = v[DW-1:0];
    bus.OUT_CLK = 1'b1;
    cycles(ph);
    bus.OUT_CLK = 1'b0;
    cycles(ph);
    if (m_armed && m_cnt < DEPTH) begin
      if (!m_trig && (!m_mode || v >= m_th)) m_trig = 1'b1;
      if (m_trig) begin
        sbq.push_back(v);
        m_cnt++;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (bus.DONE !== 1'b1 && k < 40) begin
      cycles(1);
      k++;
    end
    chk(tag, bus.DONE, 1);
  endtask

  task automatic read_burst(input int n);
    longint e;
    for (int i = 0; i < n; i++) begin
      bus.RD_REQ = 1'b1;
      cycles(1);
      chk("rd_valid", bus.RD_VALID, 1);
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("rd_data", bus.RD_DATA, e);
      end
    end
    bus.RD_REQ = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_data"}, bus.RD_DATA, 0);
    chk({tag, "_rd_valid"}, bus.RD_VALID, 0);
    chk({tag, "_busy"}, bus.BUSY, 0);
    chk({tag, "_done"}, bus.DONE, 0);
    chk({tag, "_overrun"}, bus.OVERRUN, 0);
    chk({tag, "_cnt"}, bus.SAMPLE_CNT, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RES           = 1'b1;
    bus.OUT_CLK   = 1'b0;
    bus.OUT       = '0;
    bus.ARM       = 1'b0;
    bus.TRIG_MODE = 1'b0;
    bus.THRESH    = '0;
    bus.RD_REQ    = 1'b0;
    m_armed       = 1'b0;
    cycles(3);
    check_idle_outputs("reset");
    RES = 1'b0;
    cycles(2);

    // Immediate ramp, 8/8 strobe, overrun on the spare samples.
    bus.TRIG_MODE = 1'b0;
    bus.ARM       = 1'b1;
    arm_model(1'b0, 0);
    cycles(3);
    chk("ramp_busy", bus.BUSY, 1);
    for (int i = 0; i < DEPTH; i++) send(i, 8);
    wait_done("ramp_done");
    chk("ramp_cnt", bus.SAMPLE_CNT, DEPTH);
    chk("ramp_ovr_pre", bus.OVERRUN, 0);
    for (int i = DEPTH; i < 70; i++) begin
      send(i, 8);
      chk("ramp_ovr", bus.OVERRUN, 1);
    end
    bus.ARM = 1'b0;
    cycles(2);
    chk("ramp_arm_ignored", bus.DONE, 1);
    read_burst(DEPTH);
    chk("ramp_done_clr", bus.DONE, 0);
    chk("ramp_busy_clr", bus.BUSY, 0);
    bus.RD_REQ = 1'b1;
    cycles(1);
    chk("ramp_rd_ignored", bus.RD_VALID, 0);
    bus.RD_REQ = 1'b0;
    cycles(2);

    // Threshold trigger at -5, 4/4 strobe.
    bus.TRIG_MODE = 1'b1;
    bus.THRESH    = -5;
    bus.ARM       = 1'b1;
    arm_model(1'b1, -5);
    cycles(3);
    send(-20, 4);
    send(-10, 4);
    chk("thr_not_trig", bus.SAMPLE_CNT, 0);
    send(-5, 4);
    chk("thr_trig", bus.SAMPLE_CNT, 1);
    for (int i = 3; i <= 65; i++) send(i, 4);
    wait_done("thr_done");
    bus.ARM = 1'b0;
    chk("thr_first", sbq[0], -5);
    read_burst(DEPTH);
    cycles(2);

    // Sign extremes against THRESH=0.
    bus.THRESH = 0;
    bus.ARM    = 1'b1;
    arm_model(1'b1, 0);
    cycles(3);
    send(-1048576, 4);
    chk("sgn_busy", bus.BUSY, 1);
    chk("sgn_not_trig", bus.SAMPLE_CNT, 0);
    for (int i = 1; i <= DEPTH; i++) send((i % 2) ? 1048575 : -1048576, 4);
    wait_done("sgn_done");
    bus.ARM = 1'b0;
    read_burst(DEPTH);
    cycles(2);

    // Abort after 10 words.
    bus.TRIG_MODE = 1'b0;
    bus.ARM       = 1'b1;
    arm_model(1'b0, 0);
    cycles(3);
    for (int i = 0; i < 10; i++) send(500 + i, 4);
    cycles(2);
    bus.ARM = 1'b0;
    m_armed = 1'b0;
    sbq.delete();
    cycles(2);
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_done", bus.DONE, 0);
    chk("abort_cnt", bus.SAMPLE_CNT, 10);
    bus.RD_REQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("abort_no_valid", bus.RD_VALID, 0);
    end
    bus.RD_REQ = 1'b0;
    cycles(2);

    // Reset during readout, then a fresh minimum-phase capture.
    bus.ARM = 1'b1;
    arm_model(1'b0, 0);
    cycles(3);
    for (int i = 0; i < DEPTH; i++) send(100 + i, 4);
    wait_done("rst_done");
    bus.ARM = 1'b0;
    read_burst(20);
    bus.RD_REQ = 1'b1;
    RES        = 1'b1;
    #1;
    check_idle_outputs("midrst");
    bus.RD_REQ = 1'b0;
    cycles(2);
    RES = 1'b0;
    cycles(2);
    bus.ARM = 1'b1;
    arm_model(1'b0, 0);
    cycles(3);
    for (int i = 0; i < DEPTH; i++) send(200 + i, 4);
    wait_done("minph_done");
    chk("minph_cnt", bus.SAMPLE_CNT, DEPTH);
    chk("minph_ovr", bus.OVERRUN, 0);
    bus.ARM = 1'b0;
    read_burst(DEPTH);
    chk("minph_sb_empty", sbq.size(), 0);
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dig_out_capture.md
Name: dig_out_capture

Overview:
- Receive-side capture block for the 21-bit signed result stream (OUT) and its strobe clock (OUT_CLK) produced by the DFE/ADC-TEG selector path.
- Runs on one fast system clock and treats OUT_CLK as a data signal: synchronizes it, detects its edges, and stores samples in an on-chip buffer.
- Supports an arm/trigger sequence, then a request/valid readout, so test equipment can pull back a burst of results at low speed.

Parameters:
- BW, 6: ADC code width; the data word width is DW = BW+15 (21 at default).
- AW, 6: buffer address width; depth is 2^AW (64).
- SYNC_STAGES, 2: number of synchronizer flops on OUT_CLK; minimum 2.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RES  in  1  asynchronous reset, active-high.
- OUT_CLK  in  1  strobe clock from the result path, asynchronous to CLK.
- OUT  in  DW signed  result word, launched on the OUT_CLK rising edge.
- ARM  in  1  level signal; high requests or holds a capture, low aborts a capture.
- TRIG_MODE  in  1  0 = trigger on the first sample; 1 = trigger on a threshold.
- THRESH  in  DW signed  threshold used when TRIG_MODE=1.
- RD_REQ  in  1  read request, one word per cycle while held high.
- RD_DATA  out  DW signed  readout word.
- RD_VALID  out  1  RD_DATA is valid this cycle.
- BUSY  out  1  state is ARMED or CAPTURE.
- DONE  out  1  buffer is full and readout is pending.
- OVERRUN  out  1  sticky flag: a sample arrived while FULL.
- SAMPLE_CNT  out  AW+1  number of words written in the current capture.

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, write and read pointers are 0, synchronizer flops are 0. Buffer contents are not reset.
- Sample strobe:
  - OUT_CLK passes through SYNC_STAGES flops, then one history flop.
  - A synchronized falling edge generates a one-cycle strobe `stb`.
  - OUT is registered into `smp` on `stb`.
  - Source requirement: OUT is stable from the OUT_CLK rise until SYNC_STAGES+2 CLK after the OUT_CLK fall.
  - OUT_CLK high and low phases are each at least SYNC_STAGES+2 CLK.
- `smp` valid: asserted one cycle after `stb` and used by the FSM. Comparisons are signed, at full DW width.
- FSM states:
  - IDLE: when ARM=1, clear SAMPLE_CNT, write pointer and OVERRUN, then go to ARMED.
  - ARMED:
    - ARM=0 -> IDLE.
    - On `smp` valid, if TRIG_MODE=0 or smp >= THRESH: write smp to address 0, set SAMPLE_CNT=1, go to CAPTURE.
    - Otherwise stay in ARMED.
  - CAPTURE:
    - ARM=0 -> IDLE. SAMPLE_CNT holds its partial count; DONE stays 0.
    - On `smp` valid: write at the write pointer, increment the pointer.
    - When SAMPLE_CNT reaches 2^AW -> FULL, with DONE=1 the following cycle.
  - FULL:
    - Each cycle with RD_REQ=1 reads mem[rd_ptr]. RD_DATA and RD_VALID appear 1 cycle later, and rd_ptr increments.
    - After word 2^AW-1 is issued -> IDLE, with DONE=0 and rd_ptr=0.
    - `smp` valid in FULL: data is discarded and OVERRUN=1.
    - ARM is ignored in FULL.
- RD_REQ outside FULL is ignored; RD_VALID stays 0. RD_VALID is a one-cycle pulse per request; back-to-back requests give back-to-back valids.
- SAMPLE_CNT saturates at 2^AW. The write pointer wraps to 0 naturally, but no write happens once FULL.
- If `smp` valid and ARM=0 occur in the same cycle in ARMED/CAPTURE, the abort wins and no write happens.
- If ARM is still high when FULL returns to IDLE, a new capture re-arms the next cycle.
- RES asserted mid-capture or mid-read returns the block to the reset state immediately.

Test Plan:
- Immediate ramp: TRIG_MODE=0, ARM=1, OUT counts 0..69 with OUT_CLK at 8 CLK high / 8 CLK low.
  - DONE=1, SAMPLE_CNT=64.
  - RD_REQ held 64 cycles -> RD_DATA=0..63 in order, RD_VALID for 64 consecutive cycles.
  - OVERRUN=1 from sample 64.
  - State returns to IDLE and DONE=0.
- Threshold: TRIG_MODE=1, THRESH=-5, OUT = -20,-10,-5,3,... -> first stored word is -5. Words -20 and -10 are not stored.
- Sign extremes: OUT=+1048575 and -1048576 with THRESH=0 -> only the positive value triggers; both values read back bit-exact.
- Abort: ARM drops after 10 captured words -> IDLE, BUSY=0, DONE=0, SAMPLE_CNT=10. RD_REQ produces no RD_VALID.
- Reset mid-readout: RES pulsed after 20 reads -> all outputs 0. A new ARM capture restarts at address 0.
- Minimum-phase OUT_CLK (4/4 CLK with SYNC_STAGES=2) -> all 64 samples are captured without loss or duplication.
